// File: rtl/cpu_step_ctl_pkg.sv
// Shared types and default widths for the 6502 clock-enable / debug-run controller.
package cpu_step_ctl_pkg;

  localparam int DIV_W_DEF  = 17;
  localparam int ADDR_W_DEF = 16;
  localparam int CNT_W_DEF  = 24;

  typedef enum logic [1:0] {
    ST_HALT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STEP_CYC = 2'd2,
    ST_STEP_INS = 2'd3
  } state_e;

endpackage

// File: rtl/cpu_step_ctl_if.sv
// Control/observe bundle between the debug host and cpu_step_ctl; slave is the controller.
interface cpu_step_ctl_if
  import cpu_step_ctl_pkg::*;
#(
  parameter int DIV_W  = DIV_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  logic [DIV_W-1:0]  divisor;
  logic              run_req;
  logic              halt_req;
  logic              step_req;
  logic              step_mode;
  logic              sync;
  logic [ADDR_W-1:0] addr;
  logic              bp_en;
  logic [ADDR_W-1:0] bp_addr;
  logic              cpu_ce;
  logic              halted;
  logic              bp_hit;
  logic [CNT_W-1:0]  cycle_count;

  modport master (
    output divisor, run_req, halt_req, step_req, step_mode, sync, addr, bp_en, bp_addr,
    input  cpu_ce, halted, bp_hit, cycle_count
  );

  modport slave (
    input  divisor, run_req, halt_req, step_req, step_mode, sync, addr, bp_en, bp_addr,
    output cpu_ce, halted, bp_hit, cycle_count
  );

endinterface

// File: rtl/cpu_step_ctl_clk_en_div.sv
// Runtime divider: tick when the count reaches the divisor, then restart from zero.
// clr holds the count at zero and masks tick.
module clk_en_div #(
  parameter int DIV_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [DIV_W-1:0] divisor,
  output logic             tick
);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;

  // ">=" lets a lowered divisor take effect on the very next clk
  always_comb begin
    tick      = !clr && (div_cnt_q >= divisor);
    div_cnt_d = div_cnt_q + DIV_W'(1);
    if (clr || tick) begin
      div_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/cpu_step_ctl.sv
// Clock-enable and debug-run controller for the 6502 core: divider-paced cpu_ce with
// HALT / RUN / cycle-step / instruction-step modes and a single address breakpoint.
module cpu_step_ctl
  import cpu_step_ctl_pkg::*;
#(
  parameter int DIV_W  = DIV_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  cpu_step_ctl_if.slave  bus
);

  state_e           state_q, state_d;
  logic             cpu_ce_q, cpu_ce_d;
  logic             halted_q, halted_d;
  logic             bp_hit_q, bp_hit_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic             tick;
  logic             div_clr;
  logic             bp_match;
  logic             stop;

  assign div_clr = (state_q == ST_HALT);

  clk_en_div #(.DIV_W(DIV_W)) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (div_clr),
    .divisor (bus.divisor),
    .tick    (tick)
  );

  assign bp_match = bus.bp_en && bus.sync && (bus.addr == bus.bp_addr);

  // stop suppresses the cpu_ce a same-clk tick would otherwise issue
  always_comb begin
    state_d  = state_q;
    bp_hit_d = bp_hit_q;
    stop     = 1'b0;
    if (bus.halt_req) begin
      state_d = ST_HALT;
      stop    = 1'b1;
    end else if ((state_q == ST_RUN) && cpu_ce_q && bp_match) begin
      state_d  = ST_HALT;
      bp_hit_d = 1'b1;
      stop     = 1'b1;
    end else if (bus.run_req) begin
      state_d  = ST_RUN;
      bp_hit_d = 1'b0;
    end else begin
      case (state_q)
        ST_HALT: begin
          if (bus.step_req) begin
            state_d = bus.step_mode ? ST_STEP_INS : ST_STEP_CYC;
          end
        end
        ST_STEP_CYC: begin
          if (tick) begin
            state_d = ST_HALT;
          end
        end
        ST_STEP_INS: begin
          // cpu_ce_q is never high on entry from HALT, so this is always after a pulse
          if (cpu_ce_q && bus.sync) begin
            state_d = ST_HALT;
            stop    = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
    cpu_ce_d      = tick && !stop;
    halted_d      = (state_d == ST_HALT);
    cycle_count_d = cycle_count_q + CNT_W'(cpu_ce_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_HALT;
      cpu_ce_q      <= 1'b0;
      halted_q      <= 1'b1;
      bp_hit_q      <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cpu_ce_q      <= cpu_ce_d;
      halted_q      <= halted_d;
      bp_hit_q      <= bp_hit_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign bus.cpu_ce      = cpu_ce_q;
  assign bus.halted      = halted_q;
  assign bus.bp_hit      = bp_hit_q;
  assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_step_ctl.sv
// Scoreboarded bench for cpu_step_ctl: directed scenarios followed by randomized control traffic.
module tb_cpu_step_ctl;
  import cpu_step_ctl_pkg::*;

  localparam int DW = 17;
  localparam int AW = 16;
  localparam int CW = 24;
  localparam longint CNT_MOD = longint'(1) << CW;

  typedef struct {
    logic          ce;
    logic          halted;
    logic          bp;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cpu_step_ctl_if #(.DIV_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();

  cpu_step_ctl #(.DIV_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t   exp_q[$];
  int     vectors = 0;
  int     miscompares = 0;
  longint ce_total = 0;
  longint base;
  int     load_req = 0;
  int     load_done = 0;
  longint load_val = 0;

  // Reference: 0 = halted, 1 = running, 2 = single cycle step, 3 = single instruction step
  int     m_mode = 0;
  longint m_since = 0;
  bit     m_ce = 0;
  bit     m_bp = 0;
  longint m_cnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: dut=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_loop();
    exp_t e;
    bit   tick;
    bit   stop;
    int   nm;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_mode = 0; m_since = 0; m_ce = 0; m_bp = 0; m_cnt = 0;
      end else begin
        tick = (m_mode != 0) && (m_since >= longint'(bus.divisor));
        stop = 0;
        nm   = m_mode;
        if (bus.halt_req) begin
          nm = 0; stop = 1;
        end else if (m_mode == 1 && m_ce && bus.bp_en && bus.sync && bus.addr == bus.bp_addr) begin
          nm = 0; stop = 1; m_bp = 1;
        end else if (bus.run_req) begin
          nm = 1; m_bp = 0;
        end else if (m_mode == 0 && bus.step_req) begin
          nm = bus.step_mode ? 3 : 2;
        end else if (m_mode == 2 && tick) begin
          nm = 0;
        end else if (m_mode == 3 && m_ce && bus.sync) begin
          nm = 0; stop = 1;
        end
        m_since = (m_mode == 0 || tick) ? 0 : m_since + 1;
        m_ce    = tick && !stop;
        if (m_ce) m_cnt = (m_cnt + 1) % CNT_MOD;
        m_mode  = nm;
      end
      if (load_req != load_done) begin
        m_cnt     = load_val;
        load_done = load_req;
      end
      e.ce     = m_ce;
      e.halted = (m_mode == 0);
      e.bp     = m_bp;
      e.cnt    = CW'(m_cnt);
      exp_q.push_back(e);
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.cpu_ce === 1'b1) ce_total++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_cpu_ce", bus.cpu_ce, e.ce);
        chk("sb_halted", bus.halted, e.halted);
        chk("sb_bp_hit", bus.bp_hit, e.bp);
        chk("sb_cycle_count", bus.cycle_count, e.cnt);
      end
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse(input int which);
    case (which)
      0: bus.run_req = 1'b1;
      1: bus.halt_req = 1'b1;
      default: bus.step_req = 1'b1;
    endcase
    wait_n(1);
    bus.run_req = 1'b0; bus.halt_req = 1'b0; bus.step_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.divisor = '0; bus.run_req = 1'b0; bus.halt_req = 1'b0; bus.step_req = 1'b0;
    bus.step_mode = 1'b0; bus.sync = 1'b0; bus.addr = '0; bus.bp_en = 1'b0; bus.bp_addr = '0;
    fork
      model_loop();
      monitor_loop();
    join_none
    wait_n(3);
    rst_n = 1'b1;
    chk("rst_halted", bus.halted, 1);
    chk("rst_cpu_ce", bus.cpu_ce, 0);
    chk("rst_bp_hit", bus.bp_hit, 0);
    chk("rst_count", bus.cycle_count, 0);

    // divisor 3: one pulse every 4th clk
    bus.divisor = DW'(3);
    pulse(0);
    wait_n(20);
    chk("div3_count", bus.cycle_count, 5);
    chk("div3_ce_on_20", bus.cpu_ce, 1);
    pulse(1);
    chk("div3_halt_halted", bus.halted, 1);
    chk("div3_halt_ce", bus.cpu_ce, 0);

    // divisor 0: pulse every clk, halt stops at once
    bus.divisor = DW'(0);
    pulse(0);
    base = ce_total;
    wait_n(4);
    chk("div0_pulses", ce_total - base, 4);
    chk("div0_count", bus.cycle_count, 9);
    pulse(1);
    base = ce_total;
    chk("div0_halt_ce", bus.cpu_ce, 0);
    chk("div0_halted", bus.halted, 1);
    wait_n(3);
    chk("div0_no_ce_after_halt", ce_total - base, 0);

    // cycle step, divisor 2
    bus.divisor = DW'(2);
    bus.step_mode = 1'b0;
    pulse(2);
    base = ce_total;
    wait_n(2);
    chk("cstep_early", ce_total - base, 0);
    wait_n(1);
    chk("cstep_one", ce_total - base, 1);
    wait_n(3);
    chk("cstep_total", ce_total - base, 1);
    chk("cstep_halted", bus.halted, 1);

    // instruction step: sync on the 3rd pulse
    bus.divisor = DW'(0);
    bus.step_mode = 1'b1;
    pulse(2);
    base = ce_total;
    repeat (8) begin
      wait_n(1);
      bus.sync = ((ce_total - base) == 3);
    end
    bus.sync = 1'b0;
    chk("istep_pulses", ce_total - base, 3);
    chk("istep_halted", bus.halted, 1);

    // breakpoint at 0x0203
    bus.bp_en = 1'b1;
    bus.bp_addr = AW'(16'h0203);
    bus.addr = AW'(16'h0200);
    bus.sync = 1'b1;
    pulse(0);
    base = ce_total;
    repeat (8) begin
      wait_n(1);
      bus.addr = AW'(16'h0200 + (ce_total - base));
    end
    chk("bp_halted", bus.halted, 1);
    chk("bp_hit", bus.bp_hit, 1);
    chk("bp_pulses", ce_total - base, 3);
    bus.bp_en = 1'b0;
    bus.sync = 1'b0;
    pulse(0);
    chk("bp_cleared", bus.bp_hit, 0);
    chk("bp_rerun", bus.halted, 0);
    pulse(1);

    // reset mid instruction step
    bus.divisor = DW'(100);
    bus.step_mode = 1'b1;
    pulse(2);
    wait_n(30);
    rst_n = 1'b0;
    wait_n(1);
    chk("mid_rst_halted", bus.halted, 1);
    chk("mid_rst_ce", bus.cpu_ce, 0);
    chk("mid_rst_bp", bus.bp_hit, 0);
    chk("mid_rst_count", bus.cycle_count, 0);
    rst_n = 1'b1;
    wait_n(1);

    // counter wrap
    load_val = CNT_MOD - 2;
    load_req++;
    force dut.cycle_count_q = 24'hFFFFFE;
    wait_n(1);
    release dut.cycle_count_q;
    chk("wrap_preload", bus.cycle_count, CNT_MOD - 2);
    bus.divisor = DW'(0);
    bus.step_mode = 1'b0;
    pulse(2);
    wait_n(1);
    chk("wrap_max", bus.cycle_count, CNT_MOD - 1);
    pulse(2);
    wait_n(1);
    chk("wrap_zero", bus.cycle_count, 0);
    chk("wrap_ce", bus.cpu_ce, 1);

    // randomized control traffic
    bus.bp_addr = AW'(16'h0203);
    repeat (3000) begin
      bus.run_req   = ($urandom % 40) == 0;
      bus.halt_req  = ($urandom % 30) == 0;
      bus.step_req  = ($urandom % 8) == 0;
      bus.step_mode = $urandom % 2;
      bus.sync      = ($urandom % 3) == 0;
      bus.addr      = AW'(16'h0200 + $urandom_range(0, 3));
      if (($urandom % 50) == 0) bus.divisor = DW'($urandom_range(0, 5));
      if (($urandom % 100) == 0) bus.bp_en = $urandom % 2;
      rst_n = ($urandom % 500) != 0;
      wait_n(1);
    end
    rst_n = 1'b1;
    bus.run_req = 1'b0; bus.halt_req = 1'b0; bus.step_req = 1'b0;
    wait_n(3);
    chk("sb_drained", exp_q.size() <= 1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
